reg_file_mp_sb: RTL and testbench

// - Parametrised multi-port register file with write-to-read bypass and per-register busy scoreboard.
// - Sits in ID: decode reads sources and reserves the destination; WB writes results back and clears busy.
// - Replaces the fixed 2R/1W file. Adds N read / M write ports, same-cycle forwarding, hazard tracking and flush.

---
 rtl/reg_file_mp_sb_pkg.sv | 20 ++
 rtl/reg_file_mp_sb_scoreboard.sv | 85 ++++++++
 rtl/reg_file_mp_sb.sv | 85 ++++++++
 tb/tb_reg_file_mp_sb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_sb_pkg.sv
// Shared helpers for the multi-port register file: address width and address qualification.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 16;

    function automatic int unsigned rf_aw(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // False for out-of-range addresses and for the hardwired zero register.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth,
                                        input int unsigned zero_reg);
        return (addr < depth) && !((zero_reg != 0) && (addr == 0));
    endfunction

    typedef logic [DEF_DATA_W-1:0]       rf_data_t;
    typedef logic [rf_aw(DEF_DEPTH)-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_mp_sb_scoreboard.sv
// Per-register busy scoreboard: tracks one outstanding producer per register.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = rf_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_vld,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic                 flush,
    output logic [AW:0]          busy_cnt
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0] wr_hit;
    logic             rsv_blocked;
    logic             rsv_take;

    always_comb begin
        wr_hit      = '0;
        rsv_blocked = 1'b0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (wr_vld[i] && (wr_addr[i*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (addr_valid(r, DEPTH, ZERO_REG) && (rsv_addr == AW'(r))) begin
                rsv_blocked = busy_q[r] && !wr_hit[r];
            end
        end
        // rst is left out of the accept term: the async reset already clears the flops.
        rsv_take  = rsv_valid && !flush && !rsv_blocked
                    && addr_valid(32'(rsv_addr), DEPTH, ZERO_REG);
        rsv_ready = !rst && !flush && !rsv_blocked;

        busy_d = busy_q;
        cnt_d  = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (rsv_take && (rsv_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end

        rd_busy = '0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (addr_valid(r, DEPTH, ZERO_REG) && (rd_addr[j*AW +: AW] == AW'(r))) begin
                    rd_busy[j] = busy_q[r] && !wr_hit[r];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with write-to-read bypass and a busy scoreboard for hazard tracking.
module reg_file_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = rf_aw(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_valid,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_ready,
    input  logic                     flush,
    output logic [AW:0]              busy_cnt
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [NUM_WR-1:0] wr_vld;

    // Ports are applied in ascending order so the highest index wins a conflict.
    always_comb begin
        regs_d = regs_q;
        wr_vld = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wr_vld[i] = wr_en[i] && addr_valid(32'(wr_addr[i*AW +: AW]), DEPTH, ZERO_REG);
            if (wr_vld[i]) begin
                regs_d[wr_addr[i*AW +: AW]] = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            if (addr_valid(32'(rd_addr[j*AW +: AW]), DEPTH, ZERO_REG)) begin
                rd_data[j*DATA_W +: DATA_W] = regs_q[rd_addr[j*AW +: AW]];
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    if (wr_vld[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
                        rd_data[j*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_vld    (wr_vld),
        .wr_addr   (wr_addr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Self-checking bench for reg_file_mp_sb: directed vector table, reset sequence, randomized run vs model.
module tb_reg_file_mp_sb;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 12;
    localparam int AW     = 4;

    logic                clk;
    logic                rst;
    logic [2*AW-1:0]     rd_addr;
    logic [2*DATA_W-1:0] rd_data;
    logic [1:0]          rd_busy;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*DATA_W-1:0] wr_data;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ready;
    logic                flush;
    logic [AW:0]         busy_cnt;

    logic [AW-1:0]     ra [2];
    logic [AW-1:0]     wa [2];
    logic [DATA_W-1:0] wd [2];

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    reg_file_mp_sb #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_mem  [DEPTH];
    bit          m_busy [DEPTH];

    function automatic bit m_valid(input int a);
        return (a > 0) && (a < DEPTH);
    endfunction

    function automatic int m_writer(input int a);
        int w = -1;
        for (int i = 0; i < 2; i++)
            if (wr_en[i] && m_valid(int'(wa[i])) && int'(wa[i]) == a) w = i;
        return w;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        int w;
        if (!m_valid(a)) return 32'h0;
        w = m_writer(a);
        return (w >= 0) ? wd[w] : m_mem[a];
    endfunction

    function automatic bit m_rdbusy(input int a);
        return m_valid(a) && m_busy[a] && (m_writer(a) < 0);
    endfunction

    function automatic bit m_ready();
        return !rst && !flush && !m_rdbusy(int'(rsv_addr));
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = 32'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit accept;
        int ra_i;
        accept = rsv_valid && m_ready();
        ra_i   = int'(rsv_addr);
        for (int i = 0; i < 2; i++)
            if (wr_en[i] && m_valid(int'(wa[i]))) m_mem[int'(wa[i])] = wd[i];
        if (flush) begin
            for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (wr_en[i] && m_valid(int'(wa[i]))) m_busy[int'(wa[i])] = 1'b0;
            if (accept && m_valid(ra_i)) m_busy[ra_i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else     m_step();
        @(negedge clk);
    endtask

    task automatic chk_model();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("rd_data[%0d]", j), rd_data[j*DATA_W +: DATA_W], m_read(int'(ra[j])));
            chk($sformatf("rd_busy[%0d]", j), 32'(rd_busy[j]), 32'(m_rdbusy(int'(ra[j]))));
        end
        chk("rsv_ready", 32'(rsv_ready), 32'(m_ready()));
        chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt()));
    endtask

    task automatic idle_inputs();
        wr_en = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        ra[0] = '0; ra[1] = '0; rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  wen;
        logic [3:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [3:0]  ra0, ra1;
        logic        rv;
        logic [3:0]  rsa;
        logic        fl;
        logic [31:0] e_rd0, e_rd1;
        logic        e_b0, e_b1, e_rdy;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // wen wa0 wa1 wd0 wd1 | ra0 ra1 | rv rsa fl | e_rd0 e_rd1 e_b0 e_b1 e_rdy e_cnt
        tbl[0]  = '{2'b01, 4'd5, 4'd0, 32'h1234, 32'h0,    4'd0,  4'd5,  1'b0, 4'd0,  1'b0, 32'h0,    32'h1234, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[1]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd3,  4'd5,  1'b0, 4'd0,  1'b0, 32'h0,    32'h1234, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[2]  = '{2'b11, 4'd7, 4'd7, 32'hAAAA, 32'hBBBB, 4'd7,  4'd5,  1'b0, 4'd0,  1'b0, 32'hBBBB, 32'h1234, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[3]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd7,  4'd4,  1'b1, 4'd4,  1'b0, 32'hBBBB, 32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[4]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd7,  4'd4,  1'b1, 4'd4,  1'b0, 32'hBBBB, 32'h0,    1'b0, 1'b1, 1'b0, 5'd1};
        tbl[5]  = '{2'b01, 4'd4, 4'd0, 32'h44,   32'h0,    4'd7,  4'd4,  1'b1, 4'd4,  1'b0, 32'hBBBB, 32'h44,   1'b0, 1'b0, 1'b1, 5'd1};
        tbl[6]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd7,  4'd4,  1'b0, 4'd4,  1'b0, 32'hBBBB, 32'h44,   1'b0, 1'b1, 1'b0, 5'd1};
        tbl[7]  = '{2'b10, 4'd0, 4'd4, 32'h0,    32'h55,   4'd7,  4'd4,  1'b0, 4'd4,  1'b0, 32'hBBBB, 32'h55,   1'b0, 1'b0, 1'b1, 5'd1};
        tbl[8]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd4,  4'd0,  1'b1, 4'd1,  1'b0, 32'h55,   32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[9]  = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd1,  4'd0,  1'b1, 4'd2,  1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1, 5'd1};
        tbl[10] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd1,  4'd2,  1'b1, 4'd6,  1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 5'd2};
        tbl[11] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd6,  4'd2,  1'b1, 4'd9,  1'b1, 32'h0,    32'h0,    1'b1, 1'b1, 1'b0, 5'd3};
        tbl[12] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd6,  4'd2,  1'b0, 4'd9,  1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[13] = '{2'b11, 4'd0, 4'd13, 32'hFFFF, 32'h1313, 4'd0, 4'd13, 1'b1, 4'd0,  1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[14] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd0,  4'd13, 1'b1, 4'd13, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[15] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd12, 4'd13, 1'b1, 4'd12, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1, 5'd0};
        tbl[16] = '{2'b00, 4'd0, 4'd0, 32'h0,    32'h0,    4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1, 5'd0};

        idle_inputs();
        rst = 1'b1;
        m_reset();
        rsv_valid = 1'b1;
        rsv_addr  = 4'd3;
        @(negedge clk);
        #1;
        chk("rst_rsv_ready", 32'(rsv_ready), 32'h0);
        chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rel_rsv_ready", 32'(rsv_ready), 32'h1);

        // Mid-cycle reset drops stored data and reservations immediately.
        wr_en = 2'b01; wa[0] = 4'd3; wd[0] = 32'hDEAD;
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        tick();
        idle_inputs();
        ra[0] = 4'd3;
        #1;
        chk("pre_rst_r3", rd_data[31:0], 32'hDEAD);
        chk("pre_rst_cnt", 32'(busy_cnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_r3", rd_data[31:0], 32'h0);
        chk("mid_rst_cnt", 32'(busy_cnt), 32'h0);
        chk("mid_rst_rdy", 32'(rsv_ready), 32'h0);
        tick();
        rst = 1'b0;
        m_reset();
        #1;
        chk("post_rst_r3", rd_data[31:0], 32'h0);
        chk("post_rst_rdy", 32'(rsv_ready), 32'h1);
        @(negedge clk);

        for (int k = 0; k < 17; k++) begin
            wr_en = tbl[k].wen; wa[0] = tbl[k].wa0; wa[1] = tbl[k].wa1;
            wd[0] = tbl[k].wd0; wd[1] = tbl[k].wd1;
            ra[0] = tbl[k].ra0; ra[1] = tbl[k].ra1;
            rsv_valid = tbl[k].rv; rsv_addr = tbl[k].rsa; flush = tbl[k].fl;
            #1;
            chk($sformatf("v%0d_rd0", k), rd_data[31:0], tbl[k].e_rd0);
            chk($sformatf("v%0d_rd1", k), rd_data[63:32], tbl[k].e_rd1);
            chk($sformatf("v%0d_busy0", k), 32'(rd_busy[0]), 32'(tbl[k].e_b0));
            chk($sformatf("v%0d_busy1", k), 32'(rd_busy[1]), 32'(tbl[k].e_b1));
            chk($sformatf("v%0d_rdy", k), 32'(rsv_ready), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d_cnt", k), 32'(busy_cnt), 32'(tbl[k].e_cnt));
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                wa[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
                wd[i] = $urandom;
                ra[i] = 4'($urandom_range(0, 15));
            end
            wr_en     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 19) == 0);
            if (n == 250) rst = 1'b1;
            if (n == 252) rst = 1'b0;
            #1;
            if (rst) m_reset();
            chk_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
